// File: rtl/spi_master.sv
// spi_master: SPI initiator. Each accepted request sends one command byte
// with dc low, then clocks in req_len read bytes with dc high and streams
// them to the local consumer as one-cycle rd_vld_o pulses.
module spi_master #(
  parameter int CLK_DIV  = 4,  // SCLK half-period in clk_i cycles (>=2)
  parameter int CS_SETUP = 4,  // cs_n fall to first SCLK low phase; also dc-settle gap (>=1)
  parameter int CS_HOLD  = 4   // last SCLK high half to cs_n rise (>=1)
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_vld_i,
  output logic       req_rdy_o,
  input  logic [7:0] req_cmd_i,
  input  logic [7:0] req_len_i,
  output logic       rd_vld_o,
  output logic [7:0] rd_data_o,
  output logic       rd_last_o,
  output logic       busy_o,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o,
  output logic       spi_cs_n_o,
  output logic       dc_o,
  input  logic       spi_miso_i
);

  localparam int HW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int WW   = $clog2(WMAX + 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(CLK_DIV - 1);
  localparam logic [WW-1:0] SETUP_LAST = WW'(CS_SETUP - 1);
  localparam logic [WW-1:0] HOLD_LAST  = WW'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_GAP, S_DATA, S_HOLD, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [HW-1:0]  half_cnt_q, half_cnt_d;
  logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     byte_cnt_q, byte_cnt_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     sh_q, sh_d;       // command bits still to be sent, MSB next
  logic [6:0]     rx_q, rx_d;       // first seven bits of the byte being received
  logic           sclk_q, sclk_d;
  logic           mosi_q, mosi_d;
  logic           cs_n_q, cs_n_d;
  logic           dc_q, dc_d;
  logic           rdy_q, rdy_d;
  logic           busy_q, busy_d;
  logic           rd_vld_q, rd_vld_d;
  logic           rd_last_q, rd_last_d;
  logic [7:0]     rd_data_q, rd_data_d;

  // Next-state and registered-output computation for the transaction FSM
  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    wait_cnt_d = wait_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    dc_d       = dc_q;
    rdy_d      = rdy_q;
    busy_d     = busy_q;
    rd_vld_d   = 1'b0;
    rd_last_d  = 1'b0;
    rd_data_d  = rd_data_q;

    case (state_q)
      S_IDLE: begin
        if (req_vld_i && rdy_q) begin
          sh_d       = req_cmd_i;
          len_d      = req_len_i;
          byte_cnt_d = 8'd0;
          wait_cnt_d = '0;
          cs_n_d     = 1'b0;
          dc_d       = 1'b0;
          busy_d     = 1'b1;
          rdy_d      = 1'b0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (wait_cnt_q == SETUP_LAST) begin
          // first low half of the command byte starts with its MSB on the wire
          half_cnt_d = '0;
          bit_cnt_d  = 3'd0;
          mosi_d     = sh_q[7];
          sh_d       = {sh_q[6:0], 1'b0};
          state_d    = S_CMD;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_CMD, S_DATA: begin
        if (half_cnt_q != HALF_LAST) begin
          half_cnt_d = half_cnt_q + 1'b1;
        end else begin
          half_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // last cycle of the high half: sample MISO and end the bit cell
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            rx_d      = {rx_q[5:0], spi_miso_i};
            if (bit_cnt_q == 3'd7) begin
              wait_cnt_d = '0;
              if (state_q == S_CMD) begin
                mosi_d = 1'b0;
                if (len_q != 8'd0) begin
                  dc_d    = 1'b1;
                  state_d = S_GAP;
                end else begin
                  state_d = S_HOLD;
                end
              end else begin
                rd_vld_d   = 1'b1;
                rd_data_d  = {rx_q, spi_miso_i};
                rd_last_d  = ((byte_cnt_q + 8'd1) == len_q);
                byte_cnt_d = byte_cnt_q + 8'd1;
                if ((byte_cnt_q + 8'd1) == len_q) begin
                  state_d = S_HOLD;
                end
              end
            end else if (state_q == S_CMD) begin
              mosi_d = sh_q[7];
              sh_d   = {sh_q[6:0], 1'b0};
            end
          end
        end
      end
      S_GAP: begin
        if (wait_cnt_q == SETUP_LAST) begin
          half_cnt_d = '0;
          bit_cnt_d  = 3'd0;
          state_d    = S_DATA;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (wait_cnt_q == HOLD_LAST) begin
          cs_n_d  = 1'b1;
          dc_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // one cycle with cs_n high before the next request can be taken
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset returns every line to its idle level at once
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      half_cnt_q <= '0;
      wait_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
      len_q      <= 8'd0;
      sh_q       <= 8'd0;
      rx_q       <= 7'd0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      dc_q       <= 1'b0;
      rdy_q      <= 1'b1;
      busy_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      dc_q       <= dc_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      rd_vld_q   <= rd_vld_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign req_rdy_o  = rdy_q;
  assign busy_o     = busy_q;
  assign rd_vld_o   = rd_vld_q;
  assign rd_last_o  = rd_last_q;
  assign rd_data_o  = rd_data_q;
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;
  assign spi_cs_n_o = cs_n_q;
  assign dc_o       = dc_q;

endmodule

// File: doc/spi_master.md
# spi_master

Host-side SPI initiator for the measurement register interface. It drives `spi_sclk`, `spi_mosi`, `spi_cs_n` and the data/command line `dc` toward `spi_slave`/`control`, and samples `spi_miso`. Each accepted request issues one command byte with `dc` low, then clocks out N read bytes with `dc` high and streams them to the local consumer. It is used as the in-chip or FPGA-side bus master and as a reusable bench driver for register reads.

## Interface
- CLK_DIV, 4: SCLK half-period in `clk_i` cycles; legal range ≥2.
- CS_SETUP, 4: `clk_i` cycles from `cs_n` falling to first SCLK low phase. Also used as the dc-settle gap between the command byte and the data bytes. Must be ≥1.
- CS_HOLD, 4: `clk_i` cycles from the last SCLK rising half ending to `cs_n` rising; ≥1.
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- req_vld_i  in  1  request valid.
- req_rdy_o  out  1  request ready; high only in IDLE.
- req_cmd_i  in  8  command byte (e.g. 0x3B = DATA_RD).
- req_len_i  in  8  number of read bytes after the command; 0 means command only.
- rd_vld_o  out  1  one-cycle pulse; a received byte is on `rd_data_o`.
- rd_data_o  out  8  received byte, MSB first on the wire.
- rd_last_o  out  1  high with the `rd_vld_o` of the final byte.
- busy_o  out  1  high from request accept until return to IDLE.
- spi_sclk_o, spi_mosi_o, spi_cs_n_o, dc_o  out  1 each  SPI and dc lines.
- spi_miso_i  in  1  slave data, synchronous to `clk_i`.

## Operation
- Request handshake: the request is accepted on a cycle where `req_vld_i & req_rdy_o`. On accept, `req_cmd_i` and `req_len_i` are latched. Requests are ignored while `busy_o` is high.
- FSM states:
  - IDLE → SETUP on accept. In SETUP, `cs_n` is 0 and `dc` is 0.
  - SETUP waits CS_SETUP cycles, then → CMD.
  - CMD shifts 8 bits, then → GAP if len>0, else → HOLD.
  - GAP: `dc` is set to 1 and SCLK stays low for CS_SETUP cycles, then → DATA.
  - DATA shifts len×8 bits with `mosi` held at 0, then → HOLD.
  - HOLD keeps SCLK low for CS_HOLD cycles, then `cs_n` goes 1, `dc` goes 0, and the FSM → IDLE.
- Bit cell: 2×CLK_DIV cycles.
  - Low half: SCLK is 0. MOSI updates at the start of the low half, MSB first.
  - High half: SCLK is 1.
  - `spi_miso_i` is sampled on the last cycle of the high half.
- Byte assembly: after the 8th sample of each DATA byte, `rd_data_o` updates and `rd_vld_o` pulses on the next cycle. `rd_last_o` is set when the byte counter equals len. There is no backpressure; the consumer must accept every pulse.
- Counters:
  - Half-period counter: ceil(log2 CLK_DIV) bits.
  - Bit counter: 3 bits, wraps 7→0.
  - Byte counter: 8 bits, compared against latched len.
  - No overflow is possible for len ≤255.

## Timing
- Reset values (applied immediately on assertion, independent of clock):
  - `spi_cs_n_o` = 1
  - `spi_sclk_o` = 0
  - `spi_mosi_o` = 0
  - `dc_o` = 0
  - `req_rdy_o` = 1
  - `busy_o` = 0
  - `rd_vld_o` = 0
  - `rd_last_o` = 0
  - `rd_data_o` = 0x00
- All outputs are registered.
- Accept cycle: `cs_n` falls and `busy_o` rises on the following edge.
- Transaction length, accept to `req_rdy_o` high, is exactly 1 + CS_SETUP + 16·CLK_DIV + (len>0 ? CS_SETUP + 16·CLK_DIV·len : 0) + CS_HOLD + 1 cycles.
- `cs_n` is high for ≥1 cycle between back-to-back transactions.
- `dc` changes only while SCLK is low: at the SETUP entry and at the GAP entry.
- Reset mid-transaction: the FSM returns to IDLE and outputs take their reset values. A partial byte is discarded and no `rd_vld_o` is produced.
- A request held with `req_vld_i` during reset is accepted on the first cycle after release.

## Test plan
- Reset: hold `rst_n_i`=0 with random inputs → `cs_n`=1, `sclk`=0, `mosi`=0, `dc`=0, `req_rdy_o`=1, no `rd_vld_o`.
- Command-only: cmd 0x3B, len 0, CLK_DIV=4 → MOSI at the 8 SCLK rises is 0,0,1,1,1,0,1,1. `dc`=0 throughout, no `rd_vld_o`, total 1+4+64+4+1=74 cycles.
- Read burst: cmd 0x3B, len 8, slave model returns 0x01..0x08 → 8 `rd_vld_o` pulses with data 0x01..0x08. `rd_last_o` only on 0x08. `dc`=1 during all 64 data SCLKs, MOSI=0.
- Back-to-back: `req_vld_i` held high for 2 requests → second accepted only after `req_rdy_o` returns. `cs_n` high ≥1 cycle between; a request asserted mid-transaction is not accepted early.
- Reset mid-DATA: assert `rst_n_i` during byte 3 of 8 → immediate reset values, no further `rd_vld_o`. The next request completes normally.
- CLK_DIV=2: cmd 0xA5, len 1 → SCLK period 4 cycles, 16 SCLK rises total. The byte is sampled correctly on the last high-half cycle.
